// File: rtl/wei_rd_sched_pkg.sv
// Shared parameters, state encoding and helpers for the weight-SRAM read scheduler.
package wei_rd_sched_pkg;

   // Number of MAC read requesters sharing the weight SRAM read port.
   localparam int unsigned MAC_NUM       = 27;
   // Consecutive write-blocked cycles before a write hold is requested.
   localparam int unsigned STALL_MAX_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // Ceiling log2, never below 1 so that index vectors stay at least one bit wide.
   function automatic int unsigned c_log_2(input int unsigned value);
      int unsigned res;
      res = 1;
      while ((64'd1 << res) < 64'(value)) res = res + 1;
      return res;
   endfunction

endpackage

// File: rtl/wei_rd_sched_rr_pick.sv
// Rotated priority encoder: returns the first set bit of elig_i scanning
// ptr_i, ptr_i+1, ..., N-1, 0, ..., ptr_i-1.
//   elig_i  : eligible requester vector
//   ptr_i   : scan start index (always < N)
//   idx_o   : selected index, 0 when nothing is eligible
//   valid_o : any requester eligible
module wei_rd_sched_rr_pick
   import wei_rd_sched_pkg::*;
#(
   parameter int unsigned N = MAC_NUM,
   parameter int unsigned W = c_log_2(N)
) (
   input  logic [N-1:0] elig_i,
   input  logic [W-1:0] ptr_i,
   output logic [W-1:0] idx_o,
   output logic         valid_o
);

   // (base + off) mod N, with base < N and off < N.
   function automatic logic [W-1:0] wrap_add(input logic [W-1:0] base, input int unsigned off);
      int unsigned sum;
      sum = 32'(base) + off;
      if (sum >= N) sum = sum - N;
      return W'(sum);
   endfunction

   // Scan from the far end of the rotation so the nearest eligible index is written last.
   always_comb begin
      idx_o   = '0;
      valid_o = |elig_i;
      for (int unsigned k = 0; k < N; k++) begin
         if (elig_i[wrap_add(ptr_i, N - 1 - k)]) idx_o = wrap_add(ptr_i, N - 1 - k);
      end
   end

endmodule

// File: rtl/wei_rd_sched.sv
// Weight SRAM read scheduler: round-robin arbitration of MAC read requests onto
// a single SRAM read port, yielding to SRAM writes, with write-hold back-pressure
// and a flush/drain sequence.
//   clk, reset (async, active-high)
//   enable      : permits read scheduling
//   flush       : stop granting, drain the in-flight read, return to idle
//   rd_req      : per-MAC read request
//   rd_avail    : per-MAC requested weight already written
//   wr_busy     : SRAM write this cycle (writes win)
//   rd_en       : SRAM read strobe (combinational)
//   rd_id       : granted MAC index (combinational, 0 when no grant)
//   rd_id_d     : rd_id delayed one cycle, aligned with read data return
//   dataout_val : one-hot read-data-valid per MAC (registered)
//   wr_hold     : request to pause weight writes (registered)
//   busy        : scheduler not idle
//   flush_done  : one-cycle pulse when drain completes (registered)
module wei_rd_sched
   import wei_rd_sched_pkg::*;
#(
   parameter int unsigned RD_NUM    = MAC_NUM,
   parameter int unsigned ID_WIDTH  = c_log_2(RD_NUM),
   parameter int unsigned STALL_MAX = STALL_MAX_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                flush,
   input  logic [RD_NUM-1:0]   rd_req,
   input  logic [RD_NUM-1:0]   rd_avail,
   input  logic                wr_busy,
   output logic                rd_en,
   output logic [ID_WIDTH-1:0] rd_id,
   output logic [ID_WIDTH-1:0] rd_id_d,
   output logic [RD_NUM-1:0]   dataout_val,
   output logic                wr_hold,
   output logic                busy,
   output logic                flush_done
);

   localparam int unsigned CNT_W = c_log_2(STALL_MAX + 1);

   state_e              state_q, state_d;
   logic [ID_WIDTH-1:0] ptr_q, ptr_d;
   logic [RD_NUM-1:0]   pending_q, pending_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
   logic [ID_WIDTH-1:0] rd_id_d_q;
   logic [RD_NUM-1:0]   dataout_val_q, dataout_val_d;
   logic                wr_hold_q, wr_hold_d;
   logic                flush_done_q, flush_done_d;

   logic [RD_NUM-1:0]   eligible;
   logic [RD_NUM-1:0]   grant_vec;
   logic [ID_WIDTH-1:0] pick_idx;
   logic                pick_valid;
   logic                grant;

   // A MAC with a read still in flight is masked to avoid back-to-back grants.
   assign eligible = rd_req & rd_avail & ~pending_q;

   wei_rd_sched_rr_pick #(
      .N (RD_NUM),
      .W (ID_WIDTH)
   ) u_rr_pick (
      .elig_i  (eligible),
      .ptr_i   (ptr_q),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; flush wins over enable while running.
   always_comb begin
      state_d      = state_q;
      flush_done_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (enable && !flush) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (flush || !enable) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // No read issued last cycle means no data still owed to a MAC.
            if (dataout_val_q == '0) begin
               state_d      = ST_IDLE;
               flush_done_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Grant, pointer, pending, stall and write-hold next-state logic.
   always_comb begin
      grant         = (state_q == ST_RUN) && pick_valid && !wr_busy;
      rd_en         = grant;
      rd_id         = grant ? pick_idx : '0;
      grant_vec     = grant ? (RD_NUM'(1) << pick_idx) : '0;
      dataout_val_d = grant_vec;
      ptr_d         = ptr_q;
      if (grant) begin
         ptr_d = (pick_idx == ID_WIDTH'(RD_NUM - 1)) ? '0 : pick_idx + ID_WIDTH'(1);
      end
      // Pending clears when the data returns and sets on a new grant.
      pending_d = (pending_q & ~dataout_val_q) | grant_vec;

      stall_cnt_d = stall_cnt_q;
      if ((state_q != ST_RUN) || (state_d != ST_RUN) || grant) begin
         stall_cnt_d = '0;
      end else if ((|eligible) && wr_busy && (stall_cnt_q < CNT_W'(STALL_MAX))) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      wr_hold_d = (stall_cnt_d == CNT_W'(STALL_MAX));
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q         <= '0;
         pending_q     <= '0;
         stall_cnt_q   <= '0;
         rd_id_d_q     <= '0;
         dataout_val_q <= '0;
         wr_hold_q     <= 1'b0;
         flush_done_q  <= 1'b0;
      end else begin
         ptr_q         <= ptr_d;
         pending_q     <= pending_d;
         stall_cnt_q   <= stall_cnt_d;
         rd_id_d_q     <= rd_id;
         dataout_val_q <= dataout_val_d;
         wr_hold_q     <= wr_hold_d;
         flush_done_q  <= flush_done_d;
      end
   end

   assign rd_id_d     = rd_id_d_q;
   assign dataout_val = dataout_val_q;
   assign wr_hold     = wr_hold_q;
   assign flush_done  = flush_done_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wei_rd_sched.sv
// Bench for wei_rd_sched: directed scenarios followed by random traffic,
// checked every cycle against a cycle-level behavioural model.
module tb_wei_rd_sched;

   localparam int N    = 27;
   localparam int IW   = 5;
   localparam int SMAX = 8;
   localparam logic [N-1:0] ALL = {N{1'b1}};

   logic          clk = 1'b0;
   logic          reset, enable, flush, wr_busy;
   logic [N-1:0]  rd_req, rd_avail;
   logic          rd_en, wr_hold, busy, flush_done;
   logic [IW-1:0] rd_id, rd_id_d;
   logic [N-1:0]  dataout_val;

   int n_pass = 0;
   int n_tot  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   wei_rd_sched #(
      .RD_NUM    (N),
      .ID_WIDTH  (IW),
      .STALL_MAX (SMAX)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .flush       (flush),
      .rd_req      (rd_req),
      .rd_avail    (rd_avail),
      .wr_busy     (wr_busy),
      .rd_en       (rd_en),
      .rd_id       (rd_id),
      .rd_id_d     (rd_id_d),
      .dataout_val (dataout_val),
      .wr_hold     (wr_hold),
      .busy        (busy),
      .flush_done  (flush_done)
   );

   // Reference model state: mode 0=idle 1=run 2=drain; m_dval = MAC owed data (-1 none).
   int           m_mode, m_ptr, m_stall, m_dval, m_idd;
   bit           m_hold, m_fdone;
   logic [N-1:0] m_pend;
   logic [N-1:0] c_elig;
   bit           c_grant;
   int           c_idx;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic mreset();
      m_mode = 0; m_ptr = 0; m_stall = 0; m_dval = -1; m_idd = 0;
      m_hold = 0; m_fdone = 0; m_pend = '0;
   endtask

   // Round-robin choice among eligible MACs starting at the pointer.
   task automatic model_comb();
      bit found;
      c_elig = rd_req & rd_avail & ~m_pend;
      c_idx  = 0;
      found  = 0;
      for (int off = 0; off < N; off++) begin
         int i;
         i = (m_ptr + off) % N;
         if (!found && c_elig[i]) begin
            c_idx = i;
            found = 1;
         end
      end
      c_grant = (m_mode == 1) && found && !wr_busy;
   endtask

   task automatic model_update();
      int nm;
      nm = m_mode;
      case (m_mode)
         0: if (enable && !flush) nm = 1;
         1: if (flush || !enable) nm = 2;
         default: if (m_dval < 0) nm = 0;
      endcase
      m_fdone = (m_mode == 2) && (nm == 0);
      if (m_dval >= 0) m_pend[m_dval] = 1'b0;
      if (c_grant) m_pend[c_idx] = 1'b1;
      if (m_mode == 1 && nm == 1) begin
         if (c_grant) m_stall = 0;
         else if ((|c_elig) && wr_busy) m_stall = (m_stall < SMAX) ? m_stall + 1 : SMAX;
      end else begin
         m_stall = 0;
      end
      m_hold = (m_stall == SMAX);
      m_dval = c_grant ? c_idx : -1;
      m_idd  = c_grant ? c_idx : 0;
      if (c_grant) m_ptr = (c_idx + 1) % N;
      m_mode = nm;
   endtask

   // One clock: inputs already applied at the preceding falling edge.
   task automatic cycle(input string tag);
      logic [N-1:0] ev;
      #1;
      if (reset) mreset();
      model_comb();
      ev = '0;
      if (m_dval >= 0) ev[m_dval] = 1'b1;
      chk({tag, ".rd_en"},       32'(rd_en),       32'(c_grant));
      chk({tag, ".rd_id"},       32'(rd_id),       c_grant ? 32'(c_idx) : 32'd0);
      chk({tag, ".rd_id_d"},     32'(rd_id_d),     32'(m_idd));
      chk({tag, ".dataout_val"}, 32'(dataout_val), 32'(ev));
      chk({tag, ".wr_hold"},     32'(wr_hold),     32'(m_hold));
      chk({tag, ".busy"},        32'(busy),        32'(m_mode != 0));
      chk({tag, ".flush_done"},  32'(flush_done),  32'(m_fdone));
      @(posedge clk);
      if (reset) mreset();
      else model_update();
      @(negedge clk);
   endtask

   int burst;

   initial begin
      reset = 1'b1; enable = 1'b0; flush = 1'b0; wr_busy = 1'b0;
      rd_req = '0; rd_avail = '0;
      mreset();
      burst = 0;
      @(negedge clk);
      repeat (2) cycle("reset");

      // Full round-robin sweep with every MAC requesting.
      reset = 1'b0; enable = 1'b1; rd_req = ALL; rd_avail = ALL;
      cycle("sweep_idle");
      #1 chk("sweep_first_id", 32'(rd_id), 32'd0);
      for (int k = 0; k < 28; k++) cycle("sweep");
      chk("sweep_dval_after_wrap", 32'(dataout_val), 32'd1);

      // Pointer wrap: ptr=25 with {3,26} eligible.
      rd_req = '0; rd_req[24] = 1'b1;
      cycle("wrap_prime");
      rd_req = '0; rd_req[3] = 1'b1; rd_req[26] = 1'b1;
      #1 chk("wrap_id26", 32'(rd_id), 32'd26);
      cycle("wrap_a");
      #1 chk("wrap_id3", 32'(rd_id), 32'd3);
      cycle("wrap_b");
      rd_req = ALL;
      #1 chk("wrap_ptr4", 32'(rd_id), 32'd4);
      cycle("wrap_c");

      // Single requester: grants on alternate cycles.
      rd_req = '0; rd_req[5] = 1'b1;
      for (int k = 0; k < 8; k++) cycle("solo5");

      // Write-blocked stall and hold.
      rd_req = '0; rd_req[0] = 1'b1; wr_busy = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         #1;
         chk("stall_rd_en", 32'(rd_en), 32'd0);
         chk("stall_hold", 32'(wr_hold), (k >= 9) ? 32'd1 : 32'd0);
         cycle("stall");
      end
      wr_busy = 1'b0;
      #1 chk("stall_release_id", 32'(rd_en), 32'd1);
      cycle("stall_release");
      #1 chk("stall_hold_clear", 32'(wr_hold), 32'd0);
      cycle("stall_after");

      // Flush while granting MAC 7.
      rd_req = '0; rd_req[7] = 1'b1; flush = 1'b1;
      #1 chk("flush_id7", 32'(rd_id), 32'd7);
      cycle("flush_grant");
      flush = 1'b0; enable = 1'b0; rd_req = ALL;
      #1 chk("flush_dval7", 32'(dataout_val), 32'h80);
      cycle("drain_a");
      cycle("drain_b");
      #1;
      chk("flush_done_pulse", 32'(flush_done), 32'd1);
      chk("flush_busy_low", 32'(busy), 32'd0);
      cycle("drain_c");
      cycle("drain_d");

      // Reset the cycle after a grant discards the in-flight read.
      enable = 1'b1;
      cycle("rst_run");
      cycle("rst_grant");
      reset = 1'b1;
      #1;
      chk("rst_dval_clear", 32'(dataout_val), 32'd0);
      chk("rst_busy_low", 32'(busy), 32'd0);
      cycle("rst_mid");
      reset = 1'b0; enable = 1'b0;
      cycle("rst_after_a");
      cycle("rst_after_b");

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         reset  = ($urandom_range(0, 249) == 0);
         enable = ($urandom_range(0, 15) != 0);
         flush  = ($urandom_range(0, 39) == 0);
         case ($urandom_range(0, 3))
            0: rd_req = ALL;
            1: rd_req = N'($urandom);
            2: rd_req = N'($urandom & $urandom & $urandom);
            default: begin
               rd_req = '0;
               rd_req[$urandom_range(0, N - 1)] = 1'b1;
            end
         endcase
         rd_avail = ($urandom_range(0, 2) == 0) ? N'($urandom) : ALL;
         if (burst == 0 && $urandom_range(0, 59) == 0) burst = $urandom_range(8, 14);
         if (burst > 0) begin
            wr_busy = 1'b1;
            burst--;
         end else begin
            wr_busy = ($urandom_range(0, 4) == 0);
         end
         cycle("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
